// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: steers a valid/ready stream into one of four channels
// through a one-word holding register, by round-robin or fixed selection.
module demux_rr_dispatcher #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          mode,
    input  logic [1:0]    fix_sel,
    input  logic [3:0]    ch_en,
    output logic [3:0]    out_valid,
    output logic [DW-1:0] out_data,
    input  logic [3:0]    out_ready,
    output logic [1:0]    sel,
    output logic          busy,
    output logic [CW-1:0] word_cnt
);
    typedef enum logic {EMPTY, HOLD} state_t;
    state_t     state, state_nxt;
    logic [1:0] rr_ptr, rr_nxt, rr_c, tgt;
    logic       rr_found, target_ok, deliver, accept;
    always_comb begin
        target_ok = mode | (|ch_en);
        deliver   = (state == HOLD) & out_ready[sel];
        in_ready  = ((state == EMPTY) | deliver) & target_ok;
        accept    = in_valid & in_ready;
        busy      = (state == HOLD);
        out_valid = (state == HOLD) ? (4'b0001 << sel) : 4'b0000;
    end
    // Search starts one past the last grant; i=4 wraps back to rr_ptr itself.
    always_comb begin
        rr_nxt   = rr_ptr;
        rr_found = 1'b0;
        rr_c     = rr_ptr;
        for (int i = 1; i <= 4; i++) begin
            rr_c = rr_ptr + 2'(i);
            if (!rr_found && ch_en[rr_c]) begin
                rr_nxt   = rr_c;
                rr_found = 1'b1;
            end
        end
        tgt = mode ? fix_sel : rr_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = HOLD;
        else if (deliver)
            state_nxt = EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            sel      <= 2'd0;
            rr_ptr   <= 2'd3;
            word_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_data <= in_data;
                sel      <= tgt;
                if (!mode)
                    rr_ptr <= rr_nxt;
            end
            if (deliver)
                word_cnt <= word_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb_demux_rr_dispatcher: directed vectors with hand-computed expectations
// for round-robin, fixed mode, stalls, async reset and counter wrap.
module tb_demux_rr_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [1:0]  fix_sel = 2'd0;
    logic [3:0]  ch_en = 4'b1111;
    logic [3:0]  out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_ready = 4'b1111;
    logic [1:0]  sel;
    logic        busy;
    logic [15:0] word_cnt;
    int checks = 0;
    int failures = 0;

    demux_rr_dispatcher #(.DW(8), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode(mode), .fix_sel(fix_sel), .ch_en(ch_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .busy(busy), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rr_words [5];
    logic [1:0] alt_sel [4];

    initial begin
        rr_words = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        alt_sel  = '{2'd1, 2'd3, 2'd1, 2'd3};
        #2;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(word_cnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        #20 rst_n = 1'b1;
        step();

        // round-robin over all channels, back-to-back
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = rr_words[i];
            chk("rr_in_ready", 32'(in_ready), 32'h1);
            step();
            chk("rr_sel", 32'(sel), 32'(i % 4));
            chk("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
            chk("rr_data", 32'(out_data), 32'(rr_words[i]));
            chk("rr_cnt", 32'(word_cnt), 32'(i));
        end
        in_valid = 1'b0;
        step();
        chk("rr_cnt_end", 32'(word_cnt), 32'd5);
        chk("rr_idle", 32'(busy), 32'h0);

        // sparse enables: channels 1 and 3 alternate
        ch_en = 4'b1010;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i);
            step();
            chk("alt_sel", 32'(sel), 32'(alt_sel[i]));
            chk("alt_valid", 32'(out_valid), 32'(4'b0001 << alt_sel[i]));
        end
        ch_en = 4'b0000;
        #1;
        chk("noen_ready_hold", 32'(in_ready), 32'h0);
        step();
        chk("noen_deliver_cnt", 32'(word_cnt), 32'd9);
        chk("noen_busy", 32'(busy), 32'h0);
        chk("noen_ready_empty", 32'(in_ready), 32'h0);

        // fixed channel 2 stalled for three cycles
        mode = 1'b1;
        fix_sel = 2'd2;
        out_ready = 4'b1011;
        in_data = 8'h5A;
        #1;
        chk("fix_ready", 32'(in_ready), 32'h1);
        step();
        in_data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'h4);
            chk("stall_data", 32'(out_data), 32'h5A);
            chk("stall_ready", 32'(in_ready), 32'h0);
            chk("stall_cnt", 32'(word_cnt), 32'd9);
            step();
        end

        // deliver and accept in the same cycle, then retarget while held
        out_ready = 4'b1111;
        fix_sel = 2'd1;
        #1;
        chk("pass_ready", 32'(in_ready), 32'h1);
        step();
        chk("pass_data", 32'(out_data), 32'h66);
        chk("pass_sel", 32'(sel), 32'd1);
        chk("pass_cnt", 32'(word_cnt), 32'd10);
        chk("pass_busy", 32'(busy), 32'h1);
        in_valid = 1'b0;
        out_ready = 4'b0000;
        fix_sel = 2'd3;
        step();
        chk("held_sel", 32'(sel), 32'd1);
        chk("held_valid", 32'(out_valid), 32'h2);
        out_ready = 4'b0010;
        step();
        chk("held_deliver_cnt", 32'(word_cnt), 32'd11);
        chk("held_deliver_busy", 32'(busy), 32'h0);

        // fixed-mode accepts left rr_ptr at 3, so next grant is channel 0
        mode = 1'b0;
        ch_en = 4'b1111;
        out_ready = 4'b0000;
        in_valid = 1'b1;
        in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        chk("rr_resume_sel", 32'(sel), 32'd0);
        chk("rr_resume_valid", 32'(out_valid), 32'h1);

        // asynchronous reset while holding a word
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_cnt", 32'(word_cnt), 32'h0);
        chk("arst_sel", 32'(sel), 32'h0);
        out_ready = 4'b1111;
        step();
        rst_n = 1'b1;
        step();
        chk("arst_no_deliver", 32'(word_cnt), 32'h0);

        // counter wrap: one accept edge, then 65535 deliver+accept edges
        mode = 1'b1;
        fix_sel = 2'd0;
        in_valid = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap_max", 32'(word_cnt), 32'hFFFF);
        chk("wrap_busy", 32'(busy), 32'h1);
        in_valid = 1'b0;
        step();
        chk("wrap_zero", 32'(word_cnt), 32'h0);
        chk("wrap_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
